ahb_subordinate_responder: RTL and testbench

- Synthesizable AHB5 subordinate that answers the bus the AVIP master agent drives.
- Decodes address-phase controls, inserts a programmable number of wait states, and reads/writes a byte-strobed local word memory.
- Signals ERROR with the mandatory two-cycle response.
- Sits directly downstream of the master interface and serves as the DUT and golden responder for master-side sequences; uses the shared AHB enums and widths.

---
 rtl/ahb_subordinate_responder_pkg.sv | 59 +++++
 rtl/ahb_strobe_ram.sv | 29 ++
 rtl/ahb_subordinate_responder.sv | 143 ++++++++++++++
 tb/tb_ahb_subordinate_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_subordinate_responder_pkg.sv
// Shared AHB types and widths used by the subordinate responder and its local RAM.
package ahb_subordinate_responder_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned WAIT_WIDTH      = $clog2(MAX_WAIT_STATES + 1);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_transfer_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } ahb_burst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahb_resp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'd0,
    HSIZE_HALFWORD = 3'd1,
    HSIZE_WORD     = 3'd2,
    HSIZE_DWORD    = 3'd3,
    HSIZE_4WORD    = 3'd4,
    HSIZE_8WORD    = 3'd5,
    HSIZE_16WORD   = 3'd6,
    HSIZE_32WORD   = 3'd7
  } hsize_e;

  typedef enum logic [3:0] {
    HPROT_OPCODE           = 4'b0000,
    HPROT_DATA             = 4'b0001,
    HPROT_PRIV_DATA        = 4'b0011,
    HPROT_BUFF_PRIV_DATA   = 4'b0111,
    HPROT_CACHE_BUFF_PRIV  = 4'b1111
  } ahb_protection_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } resp_state_e;

endpackage

// File: rtl/ahb_strobe_ram.sv
// Word memory with per-byte write enables (synchronous write) and asynchronous read.
module ahb_strobe_ram #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MEM_DEPTH  = 256,
  localparam int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_subordinate_responder.sv
// AHB5 subordinate: decodes address phase, inserts programmable wait states,
// serves a byte-strobed local memory and gives the two-cycle ERROR response.
module ahb_subordinate_responder
  import ahb_subordinate_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = ahb_subordinate_responder_pkg::ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = ahb_subordinate_responder_pkg::DATA_WIDTH,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  input  logic [WAIT_WIDTH-1:0]   wait_states,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("ahb_subordinate_responder: DATA_WIDTH must be 32 or 64");
  end
  if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ahb_subordinate_responder: MEM_DEPTH must be a power of two");
  end

  resp_state_e           state, state_d;
  logic [WAIT_WIDTH-1:0] count_q, count_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  hreadyout_q, hreadyout_d;
  ahb_resp_e             hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [ADDR_WIDTH:0]   diff;
  logic [ADDR_WIDTH-1:0] offset, word;
  logic                  below_base, addr_err, accept, ram_we, rd_phase;
  logic                  unused_ctrl;

  // Address decode; the extra MSB of diff is the borrow when HADDR < BASE_ADDR.
  assign diff       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign below_base = diff[ADDR_WIDTH];
  assign offset     = diff[ADDR_WIDTH-1:0];
  assign word       = offset >> BYTE_SHIFT;
  assign addr_err   = below_base
                   || (word >= ADDR_WIDTH'(MEM_DEPTH))
                   || (HSIZE > 3'(BYTE_SHIFT))
                   || ((HADDR & ~({ADDR_WIDTH{1'b1}} << HSIZE)) != '0);
  assign accept     = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  // Burst type and protection are accepted but play no part in the response.
  assign unused_ctrl = ^{HBURST, HPROT};

  always_comb begin
    state_d     = state;
    count_d     = count_q;
    idx_d       = idx_q;
    write_d     = write_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    case (state)
      ST_WAIT: begin
        count_d = count_q - WAIT_WIDTH'(1);
        if (count_q == WAIT_WIDTH'(1)) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYOUT high, so a new address may land here.
        state_d = ST_IDLE;
        if (accept) begin
          idx_d   = IDX_WIDTH'(word);
          write_d = HWRITE;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (wait_states != '0) begin
            state_d = ST_WAIT;
            count_d = wait_states;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
    if (state_d == ST_WAIT || state_d == ST_ERR1) hreadyout_d = 1'b0;
    if (state_d == ST_ERR1 || state_d == ST_ERR2) hresp_d = HRESP_ERROR;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      state       <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= HRDATA;
    end
  end

  // Write commits at the end of its data phase; a reset in that cycle drops it.
  assign ram_we   = (state == ST_DATA) && write_q && !HRESET;
  assign rd_phase = (state == ST_DATA) && !write_q;

  ahb_strobe_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (HCLK),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (HWDATA),
    .wstrb (HWSTRB),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rd_phase ? ram_rdata : hrdata_q;

endmodule

// File: tb/tb_ahb_subordinate_responder.sv
// Randomized scoreboard bench for ahb_subordinate_responder with a word-array reference model.
module tb_ahb_subordinate_responder;
  import ahb_subordinate_responder_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT, HWSTRB, wait_states;

  ahb_subordinate_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (32'h0)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HWDATA      (HWDATA),
    .HWSTRB      (HWSTRB),
    .HREADY      (HREADY),
    .wait_states (wait_states),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA)
  );

  // Single subordinate on the bus: combined ready is our own ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          is_err;
    bit          is_write;
    int unsigned waits;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  longint      base_addr = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pend_wdata = '0;
  logic [3:0]  pend_wstrb = '0;

  // Monitor state
  bit          in_data = 0;
  int          stalls = 0;
  int          resp_stalls = 0;
  logic [31:0] exp_hold = '0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
    longint a = longint'(addr);
    if (a < base_addr) return 1'b1;
    if ((a - base_addr) / 4 >= longint'(DEPTH)) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (a % (longint'(1) << size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One address phase; also carries the previous transfer's write data. Starts just after a posedge.
  task automatic xfer(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                      input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [3:0] ws);
    int guard = 0;
    HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
    HBURST = 3'($urandom_range(0, 7)); wait_states = ws;
    HWDATA = pend_wdata; HWSTRB = pend_wstrb;
    @(negedge HCLK);
    while (!HREADYOUT && guard < 40) begin
      @(negedge HCLK);
      guard++;
    end
    if (!HREADYOUT) check(1'b0, "ready_timeout", 64'(guard), 64'(40));
    if (sel && trans[1]) begin
      exp_t        e;
      int unsigned idx;
      e.is_err   = model_err(addr, size);
      e.is_write = wr;
      e.waits    = e.is_err ? 1 : int'(ws);
      e.rdata    = '0;
      if (!e.is_err) begin
        idx = int'((longint'(addr) - base_addr) / 4);
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          e.rdata = model_mem[idx];
        end
      end
      sb.push_back(e);
    end
    pend_wdata = wdata;
    pend_wstrb = wstrb;
    @(posedge HCLK);
    #1;
  endtask

  // Monitor: follows each data phase and checks its outcome against the scoreboard.
  always @(negedge HCLK) begin : monitor
    exp_t e;
    if (HRESET) begin
      in_data  = 0;
      exp_hold = '0;
    end else begin
      if (in_data && !HREADYOUT) begin
        stalls++;
        if (HRESP) resp_stalls++;
        check(HRDATA == exp_hold, "hrdata_hold_stall", 64'(HRDATA), 64'(exp_hold));
        if (stalls > 40) begin
          check(1'b0, "stall_timeout", 64'(stalls), 64'(40));
          in_data = 0;
        end
      end else if (in_data) begin
        in_data = 0;
        if (sb.size() == 0) begin
          check(1'b0, "sb_underflow", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check(HRESP == e.is_err, "hresp", 64'(HRESP), 64'(e.is_err));
          check(stalls == int'(e.waits), "wait_cycles", 64'(stalls), 64'(e.waits));
          check(resp_stalls == (e.is_err ? 1 : 0), "err_first_cycle", 64'(resp_stalls), 64'(e.is_err));
          if (!e.is_err && !e.is_write) begin
            check(HRDATA == e.rdata, "hrdata", 64'(HRDATA), 64'(e.rdata));
            exp_hold = e.rdata;
          end else begin
            check(HRDATA == exp_hold, "hrdata_hold", 64'(HRDATA), 64'(exp_hold));
          end
        end
      end else begin
        check(HREADYOUT && !HRESP, "idle_ready_okay", 64'({HREADYOUT, HRESP}), 64'(2'b10));
        check(HRDATA == exp_hold, "hrdata_hold_idle", 64'(HRDATA), 64'(exp_hold));
      end
      if (!in_data && HREADYOUT && HSEL && HTRANS[1]) begin
        in_data     = 1;
        stalls      = 0;
        resp_stalls = 0;
      end
    end
  end

  initial begin : stim
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  ws;
    logic [1:0]  trans;
    int          guard;

    HRESET = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWRITE = 1'b0;
    HSIZE = HSIZE_WORD; HBURST = HBURST_SINGLE; HPROT = HPROT_DATA;
    HWDATA = '0; HWSTRB = '0; wait_states = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check(HREADYOUT == 1'b1, "reset_hreadyout", 64'(HREADYOUT), 64'(1));
    check(HRESP == 1'b0, "reset_hresp", 64'(HRESP), 64'(0));
    check(HRDATA == 32'h0, "reset_hrdata", 64'(HRDATA), 64'(0));
    @(posedge HCLK);
    #1;

    // Give every word a known value.
    for (int i = 0; i < int'(DEPTH); i++)
      xfer(1'b1, HTRANS_NONSEQ, 32'(i * 4), 1'b1, HSIZE_WORD, 32'h0, 4'hF, 4'd0);

    // Zero-wait write then pipelined read of the same word.
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 4'hF, 4'd0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);
    // Three wait states.
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd3);
    // Byte strobes over zero.
    xfer(1'b1, HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD, 32'h1122_3344, 4'b0101, 4'd0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);
    // Out-of-range and misaligned errors.
    xfer(1'b1, HTRANS_NONSEQ, 32'h400, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);
    xfer(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h21, 1'b0, HSIZE_HALFWORD, 32'h0, 4'h0, 4'd2);
    xfer(1'b1, HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD, 32'hA5A5_5A5A, 4'hF, 4'd0);
    xfer(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);

    // Reset in the second wait cycle of a write to 0x30: the write must be lost.
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h30; HWRITE = 1'b1;
    HSIZE = HSIZE_WORD; wait_states = 4'd5;
    @(posedge HCLK);
    #1;
    HTRANS = HTRANS_IDLE; HWDATA = 32'hFFFF_FFFF; HWSTRB = 4'hF;
    @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check(HREADYOUT == 1'b1, "midwait_reset_hreadyout", 64'(HREADYOUT), 64'(1));
    check(HRESP == 1'b0, "midwait_reset_hresp", 64'(HRESP), 64'(0));
    @(posedge HCLK);
    #1;
    pend_wdata = '0; pend_wstrb = '0;
    xfer(1'b1, HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      size = ($urandom_range(0, 99) < 8) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 99) < 8)
        addr = 32'h400 + 32'($urandom_range(0, 1023));
      else
        addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      if ($urandom_range(0, 9) == 0)
        addr = addr + 32'($urandom_range(1, 3));
      else if (size <= 3'd2)
        addr = addr + (32'($urandom_range(0, 3)) & ~((32'd1 << size) - 32'd1));
      ws    = ($urandom_range(0, 99) < 5) ? 4'd15 : 4'($urandom_range(0, 3));
      trans = ($urandom_range(0, 99) < 75) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      xfer(($urandom_range(0, 9) != 0), trans, addr, 1'($urandom_range(0, 1)), size,
           $urandom(), 4'($urandom_range(0, 15)), ws);
    end

    xfer(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);
    xfer(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 4'h0, 4'd0);
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge HCLK);
      guard++;
    end
    check(sb.size() == 0, "sb_drain", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
